// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : ALU control codes and widths shared by the ALU decoder and exec unit
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int SHAMT_WIDTH        = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_SLT = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_ctrl_t;

    function automatic logic is_shift(input alu_ctrl_t ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// ============================================================================
// alu_comb_core : single-cycle ALU operations (add, sub, slt, xor, or, and)
// Revision : 1.0
// ============================================================================
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  alu_ctrl_t             ctrl_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] y_o
);

    logic w_lt;

    assign w_lt = ($signed(a_i) < $signed(b_i));

    // Shift codes are handled by the sequential shifter in the exec unit.
    always_comb begin
        y_o = '0;
        case (ctrl_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_SLT: y_o = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_AND: y_o = a_i & b_i;
            default: y_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// alu_exec_unit : handshaked ALU with a 1-bit-per-cycle sequential shifter
// Revision : 1.0
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CTRL_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    alu_ctrl_t               ctrl_q, ctrl_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;

    alu_ctrl_t               w_ctrl;
    logic [SHAMT_WIDTH-1:0]  w_shamt;
    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_core_y;

    assign w_ctrl   = alu_ctrl_t'(alu_ctrl[2:0]);
    assign w_shamt  = op_b[SHAMT_WIDTH-1:0];
    assign w_accept = in_valid && (state_q == S_IDLE);

    function automatic logic [DATA_WIDTH-1:0] shift1(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  left
    );
        return left ? (v << 1) : (v >> 1);
    endfunction

    alu_comb_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .ctrl_i (w_ctrl),
        .a_i    (op_a),
        .b_i    (op_b),
        .y_o    (w_core_y)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    ctrl_d = w_ctrl;
                    if (is_shift(w_ctrl) && (w_shamt != '0)) begin
                        // First bit moves on the accept edge so latency equals shamt.
                        result_d = shift1(op_a, w_ctrl == ALU_SLL);
                        cnt_d    = w_shamt - SHAMT_WIDTH'(1);
                        state_d  = (w_shamt == SHAMT_WIDTH'(1)) ? S_DONE : S_SHIFT;
                    end else begin
                        result_d = is_shift(w_ctrl) ? op_a : w_core_y;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                result_d = shift1(result_q, ctrl_q == ALU_SLL);
                cnt_d    = cnt_q - SHAMT_WIDTH'(1);
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ctrl_q   <= ALU_ADD;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_unit : directed and randomized checks against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_alu_exec_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    alu_ctrl = 3'd0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] result;
    logic          zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a << sh;
            3'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] c, input logic [DW-1:0] b);
        int sh;
        sh = int'(b % 32);
        if ((c == 3'd2 || c == 3'd5) && sh != 0) return sh;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request with out_ready=1; returns the first valid result and its latency.
    task automatic run_op(input logic [2:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] res, output logic z, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        in_valid  = 1'b1;
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_ctrl = 3'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = result;
        z   = zero;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b result=%h zero=%b, want 0/00000000/1", out_valid, result, zero);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_sub_slt();
        logic [DW-1:0] r;
        logic z;
        int lat;
        run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, r, z, lat);
        n_checks++;
        if (r !== 32'h8000_0000 || z !== 1'b0 || lat !== 1) begin
            n_fail++;
            $display("FAIL add_overflow: result=%h zero=%b lat=%0d, want 80000000/0/1", r, z, lat);
        end
        run_op(3'd1, 32'd5, 32'd5, r, z, lat);
        n_checks++;
        if (r !== 32'd0 || z !== 1'b1 || lat !== 1) begin
            n_fail++;
            $display("FAIL sub_zero: result=%h zero=%b lat=%0d, want 00000000/1/1", r, z, lat);
        end
        run_op(3'd3, 32'hFFFF_FFFF, 32'd1, r, z, lat);
        n_checks++;
        if (r !== 32'd1 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL slt_signed: result=%h zero=%b, want 00000001/0", r, z);
        end
    endtask

    task automatic test_shifts();
        logic [DW-1:0] r;
        logic z;
        int lat;
        run_op(3'd2, 32'h1, 32'd31, r, z, lat);
        n_checks++;
        if (r !== 32'h8000_0000 || lat !== 31) begin
            n_fail++;
            $display("FAIL sll_31: result=%h lat=%0d, want 80000000/31", r, lat);
        end
        run_op(3'd5, 32'h8000_0000, 32'h24, r, z, lat);
        n_checks++;
        if (r !== 32'h0800_0000 || lat !== 4) begin
            n_fail++;
            $display("FAIL srl_4: result=%h lat=%0d, want 08000000/4", r, lat);
        end
        run_op(3'd2, 32'hDEAD_BEEF, 32'hFFFF_FFE0, r, z, lat);
        n_checks++;
        if (r !== 32'hDEAD_BEEF || lat !== 1) begin
            n_fail++;
            $display("FAIL sll_shamt0: result=%h lat=%0d, want deadbeef/1", r, lat);
        end
        run_op(3'd5, 32'h8000_0001, 32'd1, r, z, lat);
        n_checks++;
        if (r !== 32'h4000_0000 || lat !== 1) begin
            n_fail++;
            $display("FAIL srl_1: result=%h lat=%0d, want 40000000/1", r, lat);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        in_valid  = 1'b1;
        alu_ctrl  = 3'd0;
        op_a      = 32'd3;
        op_b      = 32'd4;
        out_ready = 1'b0;
        tick();
        alu_ctrl = 3'd1;
        op_a     = 32'd100;
        op_b     = 32'd1;
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0 || zero !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: out_valid=%b result=%h in_ready=%b zero=%b, want 1/00000007/0/0", i, out_valid, result, in_ready, zero);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd7) begin
            n_fail++;
            $display("FAIL release: in_ready=%b out_valid=%b result=%h, want 1/0/00000007", in_ready, out_valid, result);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        in_valid  = 1'b1;
        alu_ctrl  = 3'd6;
        op_a      = 32'hF0;
        op_b      = 32'h0F;
        out_ready = 1'b1;
        tick();
        alu_ctrl = 3'd7;
        op_a     = 32'hFF;
        op_b     = 32'h3C;
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'hFF) begin
            n_fail++;
            $display("FAIL b2b_first: out_valid=%b in_ready=%b result=%h, want 1/0/000000ff", out_valid, in_ready, result);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'h3C) begin
            n_fail++;
            $display("FAIL b2b_second: out_valid=%b result=%h, want 1/0000003c", out_valid, result);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        int stale;
        in_valid  = 1'b1;
        alu_ctrl  = 3'd2;
        op_a      = 32'h1;
        op_b      = 32'd20;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b result=%h zero=%b in_ready=%b, want 0/00000000/1/1", out_valid, result, zero, in_ready);
        end
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL stale_valid: got %0d cycles of out_valid, want 0", stale);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] r, a, b, exp_r;
        logic [2:0] c;
        logic z;
        int lat, exp_lat;
        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom);
            a = $urandom;
            b = $urandom;
            if (($urandom % 4) == 0) b = a;
            exp_r   = ref_alu(c, a, b);
            exp_lat = ref_lat(c, b);
            run_op(c, a, b, r, z, lat);
            n_checks++;
            if (r !== exp_r || z !== (exp_r == 0) || lat !== exp_lat) begin
                n_fail++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: result=%h zero=%b lat=%0d, want %h/%b/%0d", i, c, a, b, r, z, lat, exp_r, (exp_r == 0), exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub_slt();
        test_shifts();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
